mac_operand_fetch: RTL and testbench
====================================

MAC_OPERAND_FETCH -- requirements
Module: mac_operand_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, data-memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, operand width.
REQ-003 SHALL have parameter ACC_WIDTH, default 5, accumulator register-file index width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port valid_in  input  1  request present.
REQ-007 SHALL have port ready_in  output  1  request accepted when high together with valid_in.
REQ-008 SHALL have ports src1_addr, src2_addr  input  ADDR_WIDTH  operand word addresses.
REQ-009 SHALL have port accumulator_addr  input  ACC_WIDTH  accumulator register index.
REQ-010 SHALL have ports mem_rd_en  output  1 and mem_rd_addr  output  ADDR_WIDTH  data-memory read request.
REQ-011 SHALL have port mem_rd_data  input  DATA_WIDTH  read data, valid the cycle after mem_rd_en.
REQ-012 SHALL have ports acc_rd_addr  output  ACC_WIDTH and acc_rd_data  input  DATA_WIDTH  combinational register-file read.
REQ-013 SHALL have ports op_src1, op_src2, op_acc  output  DATA_WIDTH each and op_acc_addr  output  ACC_WIDTH  operands for the MAC stage.
REQ-014 SHALL have ports valid_out  output  1 and ready_out  input  1  operand handshake to the MAC stage.

Function
REQ-015 SHALL implement FSM states IDLE, RD1, RD2, CAP, OUT.
REQ-016 SHALL drive ready_in high only in IDLE; transfer occurs on the edge where valid_in and ready_in are both high, then IDLE->RD1.
REQ-017 SHALL latch src1_addr, src2_addr and accumulator_addr on the accept edge; later input changes SHALL be ignored.
REQ-018 SHALL, in RD1, assert mem_rd_en with mem_rd_addr = latched src1 address; RD1->RD2.
REQ-019 SHALL, in RD2, assert mem_rd_en with mem_rd_addr = latched src2 address and capture mem_rd_data into op_src1; RD2->CAP.
REQ-020 SHALL, in CAP, capture mem_rd_data into op_src2 and acc_rd_data into op_acc; CAP->OUT.
REQ-021 SHALL keep mem_rd_en low in IDLE, CAP and OUT.
REQ-022 SHALL drive acc_rd_addr from the latched accumulator address at all times.
REQ-023 SHALL assert valid_out only in OUT, first visible after accept edge N+3, i.e. fixed 3-edge latency.
REQ-024 SHALL hold op_src1, op_src2, op_acc and op_acc_addr stable while valid_out is high and ready_out is low.
REQ-025 SHALL, on the edge where valid_out and ready_out are both high, go OUT->IDLE; throughput is one request per 5 cycles, or 4 when REQ-031 applies.
REQ-026 SHALL treat equal src1 and src2 addresses as two normal reads when REQ-031 is not in effect.

Reset
REQ-027 SHALL, on rst low, immediately force IDLE, ready_in=0 while low, valid_out=0, mem_rd_en=0, and all operand and address registers to 0.
REQ-028 SHALL abandon any in-flight request on reset mid-operation; no valid_out SHALL follow for it.
REQ-029 SHALL assert ready_in in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL use macro MAC_FETCH_SAME_ADDR_EN to select duplicate-read elimination.
REQ-031 SHALL, when MAC_FETCH_SAME_ADDR_EN is defined and latched src1 address equals src2 address, go RD1->CAP, capture mem_rd_data into both op_src1 and op_src2 in CAP, and assert valid_out after accept edge N+2.
REQ-032 SHALL, when MAC_FETCH_SAME_ADDR_EN is undefined, contain no comparator and always follow REQ-018 to REQ-020.

Structure
REQ-033 SHALL take the FSM state enum and the ADDR_WIDTH, DATA_WIDTH and ACC_WIDTH defaults from shared package mac_pkg.
REQ-034 SHALL be a single module with no sub-modules; the memory and register file are external.

Verification
REQ-035 SHALL check: mem[12]=0x10, mem[13]=0x20, acc[14]=0x5, request (12,13,14) -> valid_out at N+3 with op_src1=0x10, op_src2=0x20, op_acc=0x5, op_acc_addr=14.
REQ-036 SHALL check: ready_out held low 4 cycles in OUT -> outputs stable, ready_in low, no mem_rd_en.
REQ-037 SHALL check: rst pulsed low during RD2 -> valid_out never asserted, ready_in high the cycle after release, next request correct.
REQ-038 SHALL check: request (50,50,3) with mem[50]=0x7 -> with macro 1 memory read, valid_out at N+2, op_src1=op_src2=0x7; without macro 2 reads, valid_out at N+3.
REQ-039 SHALL check: src1_addr changed to 0xFFF one cycle after accept -> mem_rd_addr uses the latched address.
REQ-040 SHALL check: back-to-back valid_in with ready_out tied high -> accepts every 5 cycles, and every operand set is checked against the memory model.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand-fetch stage: default widths and the
// fetch FSM state encoding.
package mac_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ACC_WIDTH_DEF  = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        CAP,
        OUT
    } fetch_state_t;

endpackage

// File: rtl/mac_operand_fetch_if.sv
// Bundle of request, data-memory, register-file and MAC-side handshake signals
// around the operand-fetch stage. master = fetch stage, slave = its environment.
interface mac_operand_fetch_if
    import mac_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
);
    logic                  valid_in;
    logic                  ready_in;
    logic [ADDR_WIDTH-1:0] src1_addr;
    logic [ADDR_WIDTH-1:0] src2_addr;
    logic [ACC_WIDTH-1:0]  accumulator_addr;

    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    logic [ACC_WIDTH-1:0]  acc_rd_addr;
    logic [DATA_WIDTH-1:0] acc_rd_data;

    logic [DATA_WIDTH-1:0] op_src1;
    logic [DATA_WIDTH-1:0] op_src2;
    logic [DATA_WIDTH-1:0] op_acc;
    logic [ACC_WIDTH-1:0]  op_acc_addr;
    logic                  valid_out;
    logic                  ready_out;

    modport master (
        input  valid_in, src1_addr, src2_addr, accumulator_addr,
        input  mem_rd_data, acc_rd_data, ready_out,
        output ready_in, mem_rd_en, mem_rd_addr, acc_rd_addr,
        output op_src1, op_src2, op_acc, op_acc_addr, valid_out
    );

    modport slave (
        output valid_in, src1_addr, src2_addr, accumulator_addr,
        output mem_rd_data, acc_rd_data, ready_out,
        input  ready_in, mem_rd_en, mem_rd_addr, acc_rd_addr,
        input  op_src1, op_src2, op_acc, op_acc_addr, valid_out
    );

endinterface

// File: rtl/mac_operand_fetch.sv
// Fetches two memory operands and one accumulator for the MAC stage.
// Define MAC_FETCH_SAME_ADDR_EN to skip the second read when src1 == src2.
module mac_operand_fetch
    import mac_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_operand_fetch_if.master  bus
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] src1_q, src1_d;
    logic [ADDR_WIDTH-1:0] src2_q, src2_d;
    logic [ACC_WIDTH-1:0]  acc_addr_q, acc_addr_d;
    logic [DATA_WIDTH-1:0] op_src1_q, op_src1_d;
    logic [DATA_WIDTH-1:0] op_src2_q, op_src2_d;
    logic [DATA_WIDTH-1:0] op_acc_q, op_acc_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            src1_q     <= '0;
            src2_q     <= '0;
            acc_addr_q <= '0;
            op_src1_q  <= '0;
            op_src2_q  <= '0;
            op_acc_q   <= '0;
        end else begin
            state_q    <= state_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            acc_addr_q <= acc_addr_d;
            op_src1_q  <= op_src1_d;
            op_src2_q  <= op_src2_d;
            op_acc_q   <= op_acc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        acc_addr_d = acc_addr_q;
        op_src1_d  = op_src1_q;
        op_src2_d  = op_src2_q;
        op_acc_d   = op_acc_q;
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    src1_d     = bus.src1_addr;
                    src2_d     = bus.src2_addr;
                    acc_addr_d = bus.accumulator_addr;
                    state_d    = RD1;
                end
            end
            RD1: begin
`ifdef MAC_FETCH_SAME_ADDR_EN
                state_d = (src1_q == src2_q) ? CAP : RD2;
`else
                state_d = RD2;
`endif
            end
            RD2: begin
                // Data arriving now answers the RD1 (src1) read.
                op_src1_d = bus.mem_rd_data;
                state_d   = CAP;
            end
            CAP: begin
                op_src2_d = bus.mem_rd_data;
                op_acc_d  = bus.acc_rd_data;
`ifdef MAC_FETCH_SAME_ADDR_EN
                if (src1_q == src2_q) begin
                    op_src1_d = bus.mem_rd_data;
                end
`endif
                state_d = OUT;
            end
            OUT: begin
                if (bus.ready_out) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ready_in is gated by rst so it stays low for the whole reset pulse.
    assign bus.ready_in    = rst && (state_q == IDLE);
    assign bus.mem_rd_en   = (state_q == RD1) || (state_q == RD2);
    assign bus.mem_rd_addr = (state_q == RD2) ? src2_q : src1_q;
    assign bus.acc_rd_addr = acc_addr_q;
    assign bus.op_src1     = op_src1_q;
    assign bus.op_src2     = op_src2_q;
    assign bus.op_acc      = op_acc_q;
    assign bus.op_acc_addr = acc_addr_q;
    assign bus.valid_out   = (state_q == OUT);

endmodule

// File: tb/tb_mac_operand_fetch.sv
// Directed bench for mac_operand_fetch: memory with registered read, comb
// register file, latency/read-count/stability/reset/back-to-back checks.
module tb_mac_operand_fetch;
    import mac_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    int   rd_count;

    logic [31:0] mem [0:4095];
    logic [31:0] acc [0:31];
    logic [31:0] mem_q;

    logic [11:0] b_s1 [4];
    logic [11:0] b_s2 [4];
    logic [4:0]  b_a  [4];

    mac_operand_fetch_if bus ();

    mac_operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            mem_q    <= mem[bus.mem_rd_addr];
            rd_count <= rd_count + 1;
        end
    end

    assign bus.mem_rd_data = mem_q;
    assign bus.acc_rd_data = acc[bus.acc_rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic [11:0] s1, input logic [11:0] s2,
                          input logic [4:0] a, input int exp_lat, input int exp_reads,
                          input int hold);
        logic [31:0] e1, e2, ea;
        int lat, base;
        e1 = mem[s1];
        e2 = mem[s2];
        ea = acc[a];
        bus.src1_addr        = s1;
        bus.src2_addr        = s2;
        bus.accumulator_addr = a;
        bus.valid_in         = 1'b1;
        bus.ready_out        = 1'b0;
        check({tag, "_ready_in"}, 32'(bus.ready_in), 32'd1);
        base = rd_count;
        @(posedge clk); #1;
        // Scramble inputs right after accept; the latched copies must be used.
        bus.valid_in         = 1'b0;
        bus.src1_addr        = 12'hFFF;
        bus.src2_addr        = 12'hFFF;
        bus.accumulator_addr = 5'h1F;
        check({tag, "_rd1_en"}, 32'(bus.mem_rd_en), 32'd1);
        check({tag, "_rd1_addr"}, 32'(bus.mem_rd_addr), 32'(s1));
        lat = 0;
        while (!bus.valid_out && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_reads"}, 32'(rd_count - base), 32'(exp_reads));
        check({tag, "_op_src1"}, bus.op_src1, e1);
        check({tag, "_op_src2"}, bus.op_src2, e2);
        check({tag, "_op_acc"}, bus.op_acc, ea);
        check({tag, "_op_acc_addr"}, 32'(bus.op_acc_addr), 32'(a));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(bus.valid_out), 32'd1);
            check({tag, "_hold_src1"}, bus.op_src1, e1);
            check({tag, "_hold_src2"}, bus.op_src2, e2);
            check({tag, "_hold_acc"}, bus.op_acc, ea);
            check({tag, "_hold_acc_addr"}, 32'(bus.op_acc_addr), 32'(a));
            check({tag, "_hold_ready_in"}, 32'(bus.ready_in), 32'd0);
            check({tag, "_hold_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
        end
        bus.ready_out = 1'b1;
        @(posedge clk); #1;
        check({tag, "_done_valid"}, 32'(bus.valid_out), 32'd0);
        check({tag, "_done_ready_in"}, 32'(bus.ready_in), 32'd1);
        $display("req %s: src1=%0d src2=%0d acc=%0d lat=%0d op1=0x%0h op2=0x%0h opacc=0x%0h",
                 tag, s1, s2, a, lat, bus.op_src1, bus.op_src2, bus.op_acc);
    endtask

    initial begin
        int seen, idx_acc, idx_out, last_acc, same_lat, same_reads;
        logic accepting;
        n_checks = 0;
        n_err    = 0;
        rd_count = 0;
        mem_q    = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        for (int i = 0; i < 32; i++) acc[i] = 32'h0;
        mem[12] = 32'h10;
        mem[13] = 32'h20;
        acc[14] = 32'h5;
        mem[50] = 32'h7;
        acc[3]  = 32'h33;
        for (int i = 0; i < 4; i++) begin
            b_s1[i] = 12'(200 + 2 * i);
            b_s2[i] = 12'(201 + 2 * i);
            b_a[i]  = 5'(i + 1);
            mem[200 + 2 * i] = 32'hA000_0000 + 32'(i * 3);
            mem[201 + 2 * i] = 32'hB000_0000 + 32'(i * 7);
            acc[i + 1]       = 32'hC000_0000 + 32'(i);
        end
        bus.valid_in         = 1'b0;
        bus.src1_addr        = '0;
        bus.src2_addr        = '0;
        bus.accumulator_addr = '0;
        bus.ready_out        = 1'b1;

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_in", 32'(bus.ready_in), 32'd0);
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check("rst_op_src1", bus.op_src1, 32'd0);
        check("rst_acc_rd_addr", 32'(bus.acc_rd_addr), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_release_ready_in", 32'(bus.ready_in), 32'd1);
        @(posedge clk); #1;

        // Basic request plus 4-cycle backpressure in OUT
        do_req("basic", 12'd12, 12'd13, 5'd14, 3, 2, 4);

        // Reset pulsed while in RD2
        bus.src1_addr        = 12'd13;
        bus.src2_addr        = 12'd12;
        bus.accumulator_addr = 5'd3;
        bus.valid_in         = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_in_rd2", 32'(bus.mem_rd_addr), 32'd12);
        rst = 1'b0;
        #1;
        check("mid_rst_ready_in", 32'(bus.ready_in), 32'd0);
        check("mid_rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check("mid_rst_op_src1", bus.op_src1, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_release_ready_in", 32'(bus.ready_in), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.valid_out) seen++;
        end
        check("mid_rst_no_valid", 32'(seen), 32'd0);
        do_req("post_rst", 12'd12, 12'd13, 5'd14, 3, 2, 0);

        // Equal source addresses
`ifdef MAC_FETCH_SAME_ADDR_EN
        same_lat   = 2;
        same_reads = 1;
`else
        same_lat   = 3;
        same_reads = 2;
`endif
        do_req("same_addr", 12'd50, 12'd50, 5'd3, same_lat, same_reads, 1);

        // Back-to-back requests with ready_out tied high
        bus.ready_out        = 1'b1;
        bus.src1_addr        = b_s1[0];
        bus.src2_addr        = b_s2[0];
        bus.accumulator_addr = b_a[0];
        bus.valid_in         = 1'b1;
        idx_acc  = 0;
        idx_out  = 0;
        last_acc = 0;
        for (int c = 0; c < 40 && idx_out < 4; c++) begin
            if (bus.valid_out) begin
                check("b2b_op_src1", bus.op_src1, mem[b_s1[idx_out]]);
                check("b2b_op_src2", bus.op_src2, mem[b_s2[idx_out]]);
                check("b2b_op_acc", bus.op_acc, acc[b_a[idx_out]]);
                check("b2b_op_acc_addr", 32'(bus.op_acc_addr), 32'(b_a[idx_out]));
                $display("b2b out %0d: op1=0x%0h op2=0x%0h opacc=0x%0h",
                         idx_out, bus.op_src1, bus.op_src2, bus.op_acc);
                idx_out++;
            end
            accepting = bus.ready_in && bus.valid_in;
            if (accepting) begin
                if (idx_acc > 0) check("b2b_accept_gap", 32'(c - last_acc), 32'd5);
                last_acc = c;
                idx_acc++;
            end
            @(posedge clk); #1;
            if (accepting) begin
                if (idx_acc < 4) begin
                    bus.src1_addr        = b_s1[idx_acc];
                    bus.src2_addr        = b_s2[idx_acc];
                    bus.accumulator_addr = b_a[idx_acc];
                end else begin
                    bus.valid_in = 1'b0;
                end
            end
        end
        check("b2b_outputs", 32'(idx_out), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
